// File: rtl/rst_seq.sv
// Staged reset sequencer: holds all domains in reset, releases them one by one, then times the run.
// Latency: rst_o[0] drops HOLD_CYCLES edges after a reset event; each later stage follows STAGE_GAP edges apart.
// Backpressure: none; free-running, and a reset event (rst_i/soft_rst_i) restarts it from any state.
//
// Ports:
//   clk_i      : clock, all logic on posedge
//   rst_i      : synchronous active-high reset (priority over soft_rst_i, same effect)
//   soft_rst_i : synchronous active-high restart request
//   rst_o      : per-stage active-high reset, bit 0 released first
//   run_o      : high while every stage is released and done is not yet set
//   done_o     : sticky run-complete flag
//   cycle_o    : run-cycle counter, saturates at SIM_CYCLES
module rst_seq #(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2,
  parameter int SIM_CYCLES  = 25,
  parameter int CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                soft_rst_i,
  output logic [N_STAGES-1:0] rst_o,
  output logic                run_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    cycle_o
);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0]    GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(SIM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_END   = CNT_W'(SIM_CYCLES);

  if (N_STAGES < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || SIM_CYCLES < 1 || CNT_W < 1 ||
      (64'(SIM_CYCLES) >= (64'd1 << CNT_W))) begin : g_param_err
    $error("rst_seq: parameter out of range");
  end

  logic [1:0]          state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [N_STAGES-1:0] rst_q, rst_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;

  // Stages always clear from bit 0 upward, so the released set is a run of low
  // zeros; shifting in one more zero releases exactly the next stage and keeps
  // rst_o monotone by construction.
  logic [N_STAGES-1:0] rst_next;
  assign rst_next = rst_q << 1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    run_d   = run_q;
    done_d  = done_q;
    cycle_d = cycle_q;

    if (soft_rst_i) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      gap_d   = '0;
      rst_d   = '1;
      run_d   = 1'b0;
      done_d  = 1'b0;
      cycle_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            rst_d = rst_next;
            gap_d = '0;
            if (rst_next == '0) begin
              state_d = ST_RUN;
              run_d   = 1'b1;
              cycle_d = '0;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            rst_d = rst_next;
            if (rst_next == '0) begin
              state_d = ST_RUN;
              run_d   = 1'b1;
              cycle_d = '0;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        ST_RUN: begin
          if (cycle_q == CYC_LAST) begin
            cycle_d = CYC_END;
            run_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cycle_d = cycle_q + CNT_W'(1);
          end
        end
        default: begin
          // DONE: everything holds until the next reset event.
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      rst_q   <= '1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
      run_q   <= run_d;
      done_q  <= done_d;
      cycle_q <= cycle_d;
    end
  end

  assign rst_o   = rst_q;
  assign run_o   = run_q;
  assign done_o  = done_q;
  assign cycle_o = cycle_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: default instance plus a single-stage, one-cycle-hold, one-cycle-run instance.
// Both share stimulus; outputs are compared every cycle against a timeline model keyed on edges since the last reset event.
module tb_rst_seq;

  localparam int N0 = 3, H0 = 4, G0 = 2, S0 = 25;
  localparam int N1 = 1, H1 = 1, G1 = 2, S1 = 1;
  localparam int CW = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_i, soft_rst_i;

  logic [N0-1:0] rst_a;
  logic          run_a, done_a;
  logic [CW-1:0] cyc_a;
  logic [N1-1:0] rst_b;
  logic          run_b, done_b;
  logic [CW-1:0] cyc_b;

  rst_seq #(.N_STAGES(N0), .HOLD_CYCLES(H0), .STAGE_GAP(G0), .SIM_CYCLES(S0), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .soft_rst_i(soft_rst_i),
    .rst_o(rst_a), .run_o(run_a), .done_o(done_a), .cycle_o(cyc_a)
  );

  rst_seq #(.N_STAGES(N1), .HOLD_CYCLES(H1), .STAGE_GAP(G1), .SIM_CYCLES(S1), .CNT_W(CW)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .soft_rst_i(soft_rst_i),
    .rst_o(rst_b), .run_o(run_b), .done_o(done_b), .cycle_o(cyc_b)
  );

  int checks   = 0;
  int failures = 0;
  int e        = 0;  // edges since the last sampled reset event

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t e=%0d got=%0h exp=%0h", tag, $time, e, obs, exp);
    end
  endtask

  // Reference timeline: stage k is released once e reaches h + k*g; the run
  // starts when the last stage drops and lasts s cycles.
  function automatic logic [31:0] exp_rst(input int ev, input int n, input int h, input int g);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = (ev < h + k * g);
    return r;
  endfunction

  function automatic int t_run(input int n, input int h, input int g);
    return h + (n - 1) * g;
  endfunction

  function automatic logic [31:0] exp_cyc(input int ev, input int tr, input int s);
    if (ev < tr) return 0;
    return (ev - tr < s) ? 32'(ev - tr) : 32'(s);
  endfunction

  task automatic check_all();
    int tr0, tr1;
    logic [N0-1:0] mono;
    tr0 = t_run(N0, H0, G0);
    tr1 = t_run(N1, H1, G1);
    check_eq("rst_a",  rst_a,  exp_rst(e, N0, H0, G0));
    check_eq("run_a",  run_a,  (e >= tr0) && (e < tr0 + S0));
    check_eq("done_a", done_a, e >= tr0 + S0);
    check_eq("cyc_a",  cyc_a,  exp_cyc(e, tr0, S0));
    check_eq("rst_b",  rst_b,  exp_rst(e, N1, H1, G1));
    check_eq("run_b",  run_b,  (e >= tr1) && (e < tr1 + S1));
    check_eq("done_b", done_b, e >= tr1 + S1);
    check_eq("cyc_b",  cyc_b,  exp_cyc(e, tr1, S1));
    // Invariants stated independently of the timeline.
    check_eq("inv_run_done", run_a & done_a, 0);
    check_eq("inv_run_rst",  run_a && (rst_a != '0), 0);
    mono = rst_a & ~(rst_a >> 1);
    mono[N0-1] = 1'b0;
    check_eq("inv_mono", mono, 0);
  endtask

  task automatic drive(input logic r, input logic s);
    rst_i      = r;
    soft_rst_i = s;
  endtask

  task automatic step();
    @(posedge clk_i);
    if (rst_i || soft_rst_i) e = 0;
    else if (e < 100000) e++;
    #1;
    check_all();
  endtask

  initial begin
    bit hit;
    drive(1'b1, 1'b0);

    // Power-on reset held 3 cycles, then a full run with 10+ quiet cycles after done.
    repeat (3) step();
    drive(1'b0, 1'b0);
    repeat (45) step();

    // Fresh reset, then soft restart at E0+7 while rst_o=100.
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0);
    repeat (6) step();
    check_eq("pre_soft_rst", rst_a, 3'b100);
    drive(1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0);
    repeat (40) step();

    // Soft restart from DONE.
    check_eq("in_done", done_a, 1'b1);
    drive(1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0);

    // Run until cycle_o=10, then hold rst_i for 5 cycles.
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      if (run_a && cyc_a == 16'd10) hit = 1'b1;
    end
    check_eq("reach_cycle10", hit, 1'b1);
    drive(1'b1, 1'b0);
    repeat (5) step();
    drive(1'b0, 1'b0);
    repeat (45) step();

    // Random soft and hard restarts.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
